// File: rtl/bp_fe_bp_feedback_queue_if.sv
// Prediction-record / branch-resolution / predictor-update bundle for the gshare feedback queue.
// The front end and backend drive through master; the queue implements slave.
interface bp_fe_bp_feedback_queue_if #(
    parameter int bht_idx_width_p  = 10,
    parameter int queue_els_p      = 8,
    parameter int miss_cnt_width_p = 16
);
    localparam int cnt_width_lp = $clog2(queue_els_p) + 1;

    logic                        pred_v_i;
    logic [bht_idx_width_p-1:0]  pred_idx_i;
    logic                        pred_taken_i;
    logic                        pred_ready_o;
    logic                        res_v_i;
    logic                        res_taken_i;
    logic                        res_ready_o;
    logic                        flush_i;
    logic                        w_v_o;
    logic [bht_idx_width_p-1:0]  idx_w_o;
    logic                        correct_o;
    logic [cnt_width_lp-1:0]     count_o;
    logic [miss_cnt_width_p-1:0] miss_cnt_o;

    modport master (
        output pred_v_i, pred_idx_i, pred_taken_i, res_v_i, res_taken_i, flush_i,
        input  pred_ready_o, res_ready_o, w_v_o, idx_w_o, correct_o, count_o, miss_cnt_o
    );

    modport slave (
        input  pred_v_i, pred_idx_i, pred_taken_i, res_v_i, res_taken_i, flush_i,
        output pred_ready_o, res_ready_o, w_v_o, idx_w_o, correct_o, count_o, miss_cnt_o
    );
endinterface

// File: rtl/bp_fe_bp_feedback_queue.sv
// In-order FIFO of gshare predictions; on each in-order resolution it emits a registered
// predictor update (index, correct) and maintains a saturating mispredict counter.
module bp_fe_bp_feedback_queue #(
    parameter int bht_idx_width_p  = 10,
    parameter int queue_els_p      = 8,
    parameter int miss_cnt_width_p = 16
) (
    input  logic clk_i,
    input  logic reset_i,
    bp_fe_bp_feedback_queue_if.slave bus
);
    localparam int ptr_width_lp = $clog2(queue_els_p);
    localparam int cnt_width_lp = ptr_width_lp + 1;
    localparam logic [cnt_width_lp-1:0]     full_lp     = cnt_width_lp'(queue_els_p);
    localparam logic [miss_cnt_width_p-1:0] miss_max_lp = '1;

    function automatic logic [miss_cnt_width_p-1:0] sat_inc(input logic [miss_cnt_width_p-1:0] v);
        return (v == miss_max_lp) ? v : v + 1'b1;
    endfunction

    // Each entry is {bht index, predicted taken}
    logic [bht_idx_width_p:0]    mem [queue_els_p];
    logic [ptr_width_lp-1:0]     rd_ptr, wr_ptr;
    logic [cnt_width_lp-1:0]     count;
    logic                        w_v_p1, correct_p1;
    logic [bht_idx_width_p-1:0]  idx_w_p1;
    logic [miss_cnt_width_p-1:0] miss_cnt;

    logic                        enq_p0, deq_p0, head_taken_p0, miss_p0;
    logic [bht_idx_width_p-1:0]  head_idx_p0;
    logic [ptr_width_lp-1:0]     rd_ptr_nxt;

    // Stage p0: handshakes decided purely from registered occupancy
    assign bus.pred_ready_o = (count < full_lp);
    assign bus.res_ready_o  = (count != '0);

    assign enq_p0        = bus.pred_v_i & bus.pred_ready_o & ~bus.flush_i;
    assign deq_p0        = bus.res_v_i & bus.res_ready_o;
    assign head_idx_p0   = mem[rd_ptr][bht_idx_width_p:1];
    assign head_taken_p0 = mem[rd_ptr][0];
    assign miss_p0       = deq_p0 & (head_taken_p0 != bus.res_taken_i);
    assign rd_ptr_nxt    = rd_ptr + ptr_width_lp'(deq_p0);

    always_ff @(posedge clk_i) begin
        if (enq_p0) mem[wr_ptr] <= {bus.pred_idx_i, bus.pred_taken_i};
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (bus.flush_i) begin
            // The same-cycle dequeue is older than the flush and still retires
            rd_ptr <= rd_ptr_nxt;
            wr_ptr <= rd_ptr_nxt;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr_nxt;
            wr_ptr <= wr_ptr + ptr_width_lp'(enq_p0);
            count  <= count + cnt_width_lp'(enq_p0) - cnt_width_lp'(deq_p0);
        end
    end

    // Stage p1: registered predictor update and mispredict count
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            w_v_p1     <= 1'b0;
            idx_w_p1   <= '0;
            correct_p1 <= 1'b0;
            miss_cnt   <= '0;
        end else begin
            w_v_p1 <= deq_p0;
            if (deq_p0) begin
                idx_w_p1   <= head_idx_p0;
                correct_p1 <= ~miss_p0;
            end
            if (miss_p0) miss_cnt <= sat_inc(miss_cnt);
        end
    end

    assign bus.w_v_o      = w_v_p1;
    assign bus.idx_w_o    = idx_w_p1;
    assign bus.correct_o  = correct_p1;
    assign bus.count_o    = count;
    assign bus.miss_cnt_o = miss_cnt;
endmodule

// File: tb/tb_bp_fe_bp_feedback_queue.sv
// Scoreboard bench for the gshare feedback queue: a reference FIFO predicts each update,
// and a negedge monitor pops and compares every w_v_o pulse.
module tb_bp_fe_bp_feedback_queue;
    localparam int IW = 10;
    localparam int NE = 8;
    localparam int MW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    bp_fe_bp_feedback_queue_if #(.bht_idx_width_p(IW), .queue_els_p(NE), .miss_cnt_width_p(MW)) bus ();

    bp_fe_bp_feedback_queue #(.bht_idx_width_p(IW), .queue_els_p(NE), .miss_cnt_width_p(MW)) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .bus     (bus.slave)
    );

    int errors = 0;
    int checks = 0;
    logic [IW:0] mq [$];   // model FIFO: {idx, predicted taken}
    logic [IW:0] sb [$];   // expected updates: {idx, correct}
    int mmiss = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.w_v_o === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("unexpected_w_v", 32'(bus.idx_w_o), 32'hFFFF_FFFF);
            end else begin
                logic [IW:0] e;
                e = sb.pop_front();
                check_val("idx_w", 32'(bus.idx_w_o), 32'(e[IW:1]));
                check_val("correct", 32'(bus.correct_o), 32'(e[0]));
            end
        end
    end

    task automatic step(input bit pv, input logic [IW-1:0] pidx, input bit pt,
                        input bit rv, input bit rt, input bit fl);
        logic [IW:0] e;
        bit enq, deq;
        enq = pv && (mq.size() < NE) && !fl;
        deq = rv && (mq.size() != 0);
        if (deq) begin
            e = mq.pop_front();
            sb.push_back({e[IW:1], e[0] == rt});
            if (e[0] != rt && mmiss != (1 << MW) - 1) mmiss++;
        end
        if (fl) mq.delete();
        else if (enq) mq.push_back({pidx, pt});
        bus.pred_v_i = pv; bus.pred_idx_i = pidx; bus.pred_taken_i = pt;
        bus.res_v_i = rv; bus.res_taken_i = rt; bus.flush_i = fl;
        @(posedge clk);
        #1;
        bus.pred_v_i = 1'b0; bus.res_v_i = 1'b0; bus.flush_i = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check_val({tag, "_count"}, 32'(bus.count_o), 32'(mq.size()));
        check_val({tag, "_pred_ready"}, 32'(bus.pred_ready_o), 32'(mq.size() < NE));
        check_val({tag, "_res_ready"}, 32'(bus.res_ready_o), 32'(mq.size() != 0));
        check_val({tag, "_miss"}, 32'(bus.miss_cnt_o), 32'(mmiss));
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_count"}, 32'(bus.count_o), 32'd0);
        check_val({tag, "_w_v"}, 32'(bus.w_v_o), 32'd0);
        check_val({tag, "_idx_w"}, 32'(bus.idx_w_o), 32'd0);
        check_val({tag, "_correct"}, 32'(bus.correct_o), 32'd0);
        check_val({tag, "_miss"}, 32'(bus.miss_cnt_o), 32'd0);
        check_val({tag, "_pred_ready"}, 32'(bus.pred_ready_o), 32'd1);
        check_val({tag, "_res_ready"}, 32'(bus.res_ready_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.pred_v_i = 1'b0; bus.pred_idx_i = '0; bus.pred_taken_i = 1'b0;
        bus.res_v_i = 1'b0; bus.res_taken_i = 1'b0; bus.flush_i = 1'b0;
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("rst");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Two predictions, both resolved taken: one hit then one miss
        step(1, 10'h012, 1, 0, 0, 0);
        step(1, 10'h3FF, 0, 0, 0, 0);
        step(0, '0, 0, 1, 1, 0);
        step(0, '0, 0, 1, 1, 0);
        step(0, '0, 0, 0, 0, 0);
        check_val("t1_miss", 32'(bus.miss_cnt_o), 32'd1);
        check_state("t1");

        // Resolve while empty is ignored
        step(0, '0, 0, 1, 0, 0);
        step(0, '0, 0, 0, 0, 0);
        check_state("empty_res");

        // Fill to capacity, attempt a ninth, then drain in order
        for (int i = 0; i < NE; i++) step(1, IW'(10'h100 + i), i[0], 0, 0, 0);
        check_state("full");
        step(1, 10'h2AA, 1, 0, 0, 0);
        check_state("full_drop");
        step(1, 10'h2BB, 1, 1, 1, 0);
        check_state("full_enq_deq");
        for (int i = 0; i < NE; i++) step(0, '0, 0, 1, i[1], 0);
        step(0, '0, 0, 0, 0, 0);
        check_state("drained");

        // Occupancy 3 with steady enqueue+dequeue across the pointer wrap
        for (int i = 0; i < 3; i++) step(1, IW'($urandom_range(0, 1023)), 1'($urandom), 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(1, IW'($urandom_range(0, 1023)), 1'($urandom), 1, 1'($urandom), 0);
            check_val("wrap_count", 32'(bus.count_o), 32'd3);
        end
        for (int i = 0; i < 3; i++) step(0, '0, 0, 1, 1'($urandom), 0);
        step(0, '0, 0, 0, 0, 0);
        check_state("wrap_end");

        // Flush with 5 entries while the head resolves and 0x055 tries to enqueue
        for (int i = 0; i < 5; i++) step(1, IW'(10'h200 + i), 1, 0, 0, 0);
        step(1, 10'h055, 1, 1, 1, 1);
        check_state("flush");
        step(0, '0, 0, 1, 0, 0);
        step(0, '0, 0, 0, 0, 0);
        check_state("post_flush");

        // Asynchronous reset mid-cycle with 4 entries queued and an update pulse live
        for (int i = 0; i < 5; i++) step(1, IW'(10'h300 + i), 0, 0, 0, 0);
        step(0, '0, 0, 1, 0, 0);
        check_val("pre_rst_count", 32'(bus.count_o), 32'd4);
        #2 rst_n = 1'b0;
        mq.delete(); sb.delete(); mmiss = 0;
        #1 check_reset_outputs("mid_rst");
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(0, '0, 0, 1, 0, 0);
        step(0, '0, 0, 0, 0, 0);
        check_state("after_rst");

        // Mispredict counter saturates at all-ones
        for (int i = 0; i < 15; i++) begin
            step(1, IW'(i), 1, 0, 0, 0);
            step(0, '0, 0, 1, 0, 0);
        end
        step(0, '0, 0, 0, 0, 0);
        check_val("sat_15", 32'(bus.miss_cnt_o), 32'hF);
        for (int i = 0; i < 3; i++) begin
            step(1, IW'(i), 0, 0, 0, 0);
            step(0, '0, 0, 1, 1, 0);
        end
        step(0, '0, 0, 0, 0, 0);
        check_val("sat_hold", 32'(bus.miss_cnt_o), 32'hF);
        check_state("sat_end");

        repeat (3) step(0, '0, 0, 0, 0, 0);
        check_val("sb_drain", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bp_fe_bp_feedback_queue.md
Name: bp_fe_bp_feedback_queue

Overview:
- In-order FIFO that records each gshare prediction the front end issues: BHT index plus predicted direction.
- When the backend resolves branches in program order, it pops the oldest entry and compares the actual outcome with the stored prediction.
- It then drives the predictor's update port (w_v / idx_w / correct) one cycle later.
- Sits between the fetch-side prediction lookup and the gshare predictor's training interface; also keeps a saturating mispredict count.

Parameters:
- bht_idx_width_p, 10, width of the BHT index carried per entry; must match the predictor's bht_idx_width_p.
- queue_els_p, 8, number of in-flight predictions; power of two, >= 2.
- miss_cnt_width_p, 16, width of the saturating mispredict counter.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- pred_v_i  in  1  a prediction was issued this cycle.
- pred_idx_i  in  bht_idx_width_p  BHT read index used for that prediction.
- pred_taken_i  in  1  predicted direction (1 = taken).
- pred_ready_o  out  1  queue can accept a prediction.
- res_v_i  in  1  oldest outstanding branch resolved this cycle.
- res_taken_i  in  1  actual direction of that branch.
- res_ready_o  out  1  queue holds at least one entry.
- flush_i  in  1  discard all queued entries.
- w_v_o  out  1  predictor update valid.
- idx_w_o  out  bht_idx_width_p  predictor update index.
- correct_o  out  1  stored prediction equalled actual outcome.
- count_o  out  $clog2(queue_els_p)+1  current occupancy.
- miss_cnt_o  out  miss_cnt_width_p  saturating mispredict count.

Behaviour:
- Reset (reset_i low, asynchronous): rd/wr pointers = 0; count_o = 0; w_v_o = 0; idx_w_o = 0; correct_o = 0; miss_cnt_o = 0. Storage contents are don't-care.
- Reset outputs: pred_ready_o = 1, res_ready_o = 0.
- Ready signals are combinational from registered state only:
  - pred_ready_o = (count < queue_els_p).
  - res_ready_o = (count != 0).
- Enqueue handshake: pred_v_i & pred_ready_o. Write {pred_idx_i, pred_taken_i} at wr_ptr, then wr_ptr += 1, wrapping modulo queue_els_p.
- Dequeue handshake: res_v_i & res_ready_o. Read the head entry and pop it (rd_ptr += 1, wrapping).
- No bypass: an entry enqueued in cycle N is first resolvable in cycle N+1. When full, an enqueue is refused even if a dequeue happens in the same cycle.
- Simultaneous enqueue and dequeue (non-full, non-empty): both occur; count unchanged.
- Update output, registered, 1-cycle latency. In the cycle after a dequeue:
  - w_v_o = 1.
  - idx_w_o = head idx.
  - correct_o = (head taken == res_taken_i).
- With no dequeue, w_v_o = 0 the next cycle. idx_w_o and correct_o hold their last values.
- miss_cnt_o increments by 1 on every dequeue where correct_o will be 0. It saturates at all-ones and never wraps.
- Handshake violations are ignored with no state change: res_v_i while empty, pred_v_i while full.
- flush_i (synchronous, highest priority for enqueue):
  - A dequeue in the same cycle is still processed and produces its w_v_o; that branch is older than the flush.
  - All remaining entries are discarded and any same-cycle enqueue is dropped. Next cycle: count_o = 0, wr_ptr = rd_ptr.
- Asynchronous reset mid-operation: all state is cleared immediately. No update pulse is emitted for dropped entries.

Test Plan:
- Reset, then enqueue idx 0x012 taken and idx 0x3FF not-taken. Resolve taken, then taken -> w_v_o pulses on 2 consecutive cycles with (0x012, correct=1) then (0x3FF, correct=0); miss_cnt_o = 1; count_o = 0.
- Enqueue 8 entries back-to-back -> pred_ready_o = 0 after the 8th. A 9th pred_v_i is dropped; count_o stays 8. Resolving all 8 returns indices in enqueue order.
- Pointer wrap: continuous enqueue+dequeue in the same cycles for 20 cycles with occupancy 3 -> count_o stays 3; every w_v_o index matches FIFO order across the wrap.
- Flush with 5 entries while resolving the head and enqueuing idx 0x055 -> one w_v_o for the old head; count_o = 0 next cycle; 0x055 never appears at idx_w_o.
- Preload miss_cnt_o near saturation (width 4 for test: 15 misses, then 3 more) -> miss_cnt_o holds 0xF and does not wrap.
- Assert reset_i low mid-cycle with 4 entries queued -> all outputs reach reset values immediately, without waiting for a clock edge; after release, res_ready_o = 0.
